syn_fifo_reader: RTL

Read-side engine that drains a syn_fifo instance and presents its contents as a valid/ready output stream.
- Hides the FIFO's one-cycle registered read latency.
- Uses a 2-entry output buffer so a continuously ready sink receives one word per cycle.
- Sits between syn_fifo and any downstream consumer that applies backpressure.

---
 rtl/syn_fifo_pkg.sv | 19 +
 rtl/syn_fifo_obuf.sv | 52 +++++
 rtl/syn_fifo_reader.sv | 102 ++++++++++
 3 files changed

// File: rtl/syn_fifo_pkg.sv
// Shared constants for the syn_fifo family (FIFO and its read engine).
//   DEF_WIDTH  : default data width
//   FIFO_SIZE  : default FIFO depth
//   OBUF_DEPTH : entries in the reader output buffer (fixed at 2)
//   CNT_W      : width of the output buffer occupancy count (0..2)
//   PTR_WIDTH  : pointer width needed to address a given depth
package syn_fifo_pkg;

   localparam int unsigned DEF_WIDTH  = 8;
   localparam int unsigned FIFO_SIZE  = 16;
   localparam int unsigned OBUF_DEPTH = 2;
   localparam int unsigned CNT_W      = 2;

   // Address width for a memory of 'depth' entries (minimum 1 bit).
   function automatic int unsigned PTR_WIDTH(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/syn_fifo_obuf.sv
// Two-entry output buffer for syn_fifo_reader: circular storage with head,
// tail and occupancy count. Push and pop in the same cycle are legal.
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   i_push, i_wdata   : capture i_wdata into the tail entry
//   i_pop             : retire the head entry
//   o_count           : occupancy, 0..2
//   o_data            : head entry
module syn_fifo_obuf
   import syn_fifo_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [CNT_W-1:0] o_count,
   output logic [WIDTH-1:0] o_data
);

   logic [WIDTH-1:0] r_buf [OBUF_DEPTH];
   logic             r_head;
   logic             r_tail;
   logic [CNT_W-1:0] r_count;

   // Storage, pointers and count; a simultaneous push/pop moves both pointers
   // and leaves the count unchanged.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_buf[0] <= '0;
         r_buf[1] <= '0;
         r_head   <= 1'b0;
         r_tail   <= 1'b0;
         r_count  <= '0;
      end else begin
         if (i_push) begin
            r_buf[r_tail] <= i_wdata;
            r_tail        <= ~r_tail;
         end
         if (i_pop) begin
            r_head <= ~r_head;
         end
         r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
      end
   end

   assign o_count = r_count;
   assign o_data  = r_buf[r_head];

endmodule

// File: rtl/syn_fifo_reader.sv
// Read engine that drains a syn_fifo and presents its words as a valid/ready
// stream, hiding the FIFO's one-cycle read latency with a 2-entry buffer.
// Optional feature: define READER_LAST_EN to generate m_last every BURST_LEN
// words; otherwise m_last is tied to 0.
// Ports:
//   clk, rst         : clock, asynchronous active-low reset
//   enable           : permits new FIFO reads (buffered words always drain)
//   fifo_empty       : FIFO empty flag
//   fifo_underflow   : FIFO underflow flag
//   fifo_rdata       : FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en       : FIFO read request (combinational)
//   m_valid/m_ready  : output handshake
//   m_data           : head-of-buffer word
//   err_underflow    : sticky underflow indication
//   m_last           : last word of a burst
module syn_fifo_reader
   import syn_fifo_pkg::*;
#(
   parameter int unsigned WIDTH     = DEF_WIDTH,
   parameter int unsigned BURST_LEN = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             fifo_empty,
   input  logic             fifo_underflow,
   input  logic [WIDTH-1:0] fifo_rdata,
   output logic             fifo_rd_en,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data,
   output logic             err_underflow,
   output logic             m_last
);

   logic             r_rd_pending;
   logic             r_err_underflow;
   logic [CNT_W-1:0] w_count;
   logic [WIDTH-1:0] w_head_data;
   logic             w_pop;
   logic [2:0]       w_occupancy;

   assign w_pop   = m_valid && m_ready;
   assign m_valid = (w_count != '0);
   assign m_data  = w_head_data;

   // Occupancy after this edge, counting the read already in flight; a new
   // read is only issued if its word is guaranteed a free buffer slot.
   // Gated by rst so no word is pulled out of the FIFO and lost during reset.
   assign w_occupancy = 3'(w_count) + 3'(r_rd_pending) - 3'(w_pop);
   assign fifo_rd_en  = rst && enable && !fifo_empty && (w_occupancy < 3'(OBUF_DEPTH));

   // In-flight read marker and sticky underflow flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rd_pending    <= 1'b0;
         r_err_underflow <= 1'b0;
      end else begin
         r_rd_pending <= fifo_rd_en;
         if (fifo_underflow) begin
            r_err_underflow <= 1'b1;
         end
      end
   end

   assign err_underflow = r_err_underflow;

   syn_fifo_obuf #(
      .WIDTH (WIDTH)
   ) u_obuf (
      .clk     (clk),
      .rst     (rst),
      .i_push  (r_rd_pending),
      .i_wdata (fifo_rdata),
      .i_pop   (w_pop),
      .o_count (w_count),
      .o_data  (w_head_data)
   );

`ifdef READER_LAST_EN
   localparam logic [7:0] LAST_IDX = 8'(BURST_LEN - 1);

   logic [7:0] r_bcnt;

   // Burst position; only pops move it, so m_last holds during stalls.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_bcnt <= 8'd0;
      end else if (w_pop) begin
         r_bcnt <= m_last ? 8'd0 : r_bcnt + 8'd1;
      end
   end

   assign m_last = m_valid && (r_bcnt == LAST_IDX);
`else
   logic w_unused_burst_len;

   assign w_unused_burst_len = ^BURST_LEN;
   assign m_last             = 1'b0;
`endif

endmodule
